// File: rtl/ray_scene_dispatcher.sv
// Nearest-hit ray scan: fetches triangles, issues one coprocessor request each.
// Optional shadow-ray early exit under `define RAY_ANY_HIT_EN (adds Cmd_AnyHit).
module ray_scene_dispatcher #(
  parameter int C_SLV_DWIDTH = 32,
  parameter int C_ADDR_WIDTH = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Cmd_Start,
  input  logic [C_SLV_DWIDTH-1:0] Cmd_RayStart_X,
  input  logic [C_SLV_DWIDTH-1:0] Cmd_RayStart_Y,
  input  logic [C_SLV_DWIDTH-1:0] Cmd_RayStart_Z,
  input  logic [C_SLV_DWIDTH-1:0] Cmd_RayDir_X,
  input  logic [C_SLV_DWIDTH-1:0] Cmd_RayDir_Y,
  input  logic [C_SLV_DWIDTH-1:0] Cmd_RayDir_Z,
  input  logic [C_ADDR_WIDTH:0]   Cmd_NumTriangles,
`ifdef RAY_ANY_HIT_EN
  input  logic                    Cmd_AnyHit,
`endif
  output logic                    Cmd_Busy,
  output logic                    Tri_Rd,
  output logic [C_ADDR_WIDTH-1:0] Tri_Addr,
  input  logic [C_SLV_DWIDTH-1:0] Tri_V1_X,
  input  logic [C_SLV_DWIDTH-1:0] Tri_V1_Y,
  input  logic [C_SLV_DWIDTH-1:0] Tri_V1_Z,
  input  logic [C_SLV_DWIDTH-1:0] Tri_V2_X,
  input  logic [C_SLV_DWIDTH-1:0] Tri_V2_Y,
  input  logic [C_SLV_DWIDTH-1:0] Tri_V2_Z,
  input  logic [C_SLV_DWIDTH-1:0] Tri_V3_X,
  input  logic [C_SLV_DWIDTH-1:0] Tri_V3_Y,
  input  logic [C_SLV_DWIDTH-1:0] Tri_V3_Z,
  output logic                    Cop_Start,
  output logic [C_SLV_DWIDTH-1:0] Cop_RayStart_X,
  output logic [C_SLV_DWIDTH-1:0] Cop_RayStart_Y,
  output logic [C_SLV_DWIDTH-1:0] Cop_RayStart_Z,
  output logic [C_SLV_DWIDTH-1:0] Cop_RayDir_X,
  output logic [C_SLV_DWIDTH-1:0] Cop_RayDir_Y,
  output logic [C_SLV_DWIDTH-1:0] Cop_RayDir_Z,
  output logic [C_SLV_DWIDTH-1:0] Cop_TriangleV1_X,
  output logic [C_SLV_DWIDTH-1:0] Cop_TriangleV1_Y,
  output logic [C_SLV_DWIDTH-1:0] Cop_TriangleV1_Z,
  output logic [C_SLV_DWIDTH-1:0] Cop_TriangleV2_X,
  output logic [C_SLV_DWIDTH-1:0] Cop_TriangleV2_Y,
  output logic [C_SLV_DWIDTH-1:0] Cop_TriangleV2_Z,
  output logic [C_SLV_DWIDTH-1:0] Cop_TriangleV3_X,
  output logic [C_SLV_DWIDTH-1:0] Cop_TriangleV3_Y,
  output logic [C_SLV_DWIDTH-1:0] Cop_TriangleV3_Z,
  input  logic                    Cop_Ready,
  input  logic [1:0]              Cop_Code,
  input  logic [C_SLV_DWIDTH-1:0] Cop_T,
  output logic                    Res_Done,
  output logic                    Res_Hit,
  output logic [C_ADDR_WIDTH-1:0] Res_Index,
  output logic [C_SLV_DWIDTH-1:0] Res_T
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, ISSUE, WAIT, COMPARE, DONE
  } state_t;

  state_t state, nextState;

  logic [C_ADDR_WIDTH:0]   count;
  logic [C_ADDR_WIDTH:0]   idx;
  logic [C_ADDR_WIDTH:0]   idxInc;
  logic [1:0]              code;
  logic [C_SLV_DWIDTH-1:0] hitT;
  logic                    hitValid;
  logic                    hitBetter;
  logic                    stopEarly;

  assign Cmd_Busy  = (state != IDLE);
  assign Tri_Rd    = (state == FETCH);
  assign Cop_Start = (state == ISSUE);
  assign Tri_Addr  = idx[C_ADDR_WIDTH-1:0];
  assign idxInc    = idx + 1'b1;

  // T must be strictly positive; strict less-than keeps the lower index on ties
  assign hitValid  = (code == 2'b01) && !hitT[C_SLV_DWIDTH-1] && (hitT != '0);
  assign hitBetter = hitValid && (!Res_Hit || ($signed(hitT) < $signed(Res_T)));

`ifdef RAY_ANY_HIT_EN
  logic anyHit;
  assign stopEarly = anyHit && hitValid;
`else
  assign stopEarly = 1'b0;
`endif

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (Cmd_Start)
                 nextState = (Cmd_NumTriangles == '0) ? DONE : FETCH;
      FETCH:   nextState = LOAD;
      LOAD:    nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (Cop_Ready) nextState = COMPARE;
      COMPARE: nextState = (stopEarly || idxInc == count) ? DONE : FETCH;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state            <= IDLE;
      count            <= '0;
      idx              <= '0;
      code             <= '0;
      hitT             <= '0;
      Res_Done         <= 1'b0;
      Res_Hit          <= 1'b0;
      Res_Index        <= '0;
      Res_T            <= '0;
      Cop_RayStart_X   <= '0;
      Cop_RayStart_Y   <= '0;
      Cop_RayStart_Z   <= '0;
      Cop_RayDir_X     <= '0;
      Cop_RayDir_Y     <= '0;
      Cop_RayDir_Z     <= '0;
      Cop_TriangleV1_X <= '0;
      Cop_TriangleV1_Y <= '0;
      Cop_TriangleV1_Z <= '0;
      Cop_TriangleV2_X <= '0;
      Cop_TriangleV2_Y <= '0;
      Cop_TriangleV2_Z <= '0;
      Cop_TriangleV3_X <= '0;
      Cop_TriangleV3_Y <= '0;
      Cop_TriangleV3_Z <= '0;
`ifdef RAY_ANY_HIT_EN
      anyHit           <= 1'b0;
`endif
    end else begin
      state    <= nextState;
      Res_Done <= (state == DONE);
      case (state)
        IDLE: if (Cmd_Start) begin
          count          <= Cmd_NumTriangles;
          idx            <= '0;
          Res_Hit        <= 1'b0;
          Res_Index      <= '0;
          Res_T          <= '0;
          Cop_RayStart_X <= Cmd_RayStart_X;
          Cop_RayStart_Y <= Cmd_RayStart_Y;
          Cop_RayStart_Z <= Cmd_RayStart_Z;
          Cop_RayDir_X   <= Cmd_RayDir_X;
          Cop_RayDir_Y   <= Cmd_RayDir_Y;
          Cop_RayDir_Z   <= Cmd_RayDir_Z;
`ifdef RAY_ANY_HIT_EN
          anyHit         <= Cmd_AnyHit;
`endif
        end
        LOAD: begin
          Cop_TriangleV1_X <= Tri_V1_X;
          Cop_TriangleV1_Y <= Tri_V1_Y;
          Cop_TriangleV1_Z <= Tri_V1_Z;
          Cop_TriangleV2_X <= Tri_V2_X;
          Cop_TriangleV2_Y <= Tri_V2_Y;
          Cop_TriangleV2_Z <= Tri_V2_Z;
          Cop_TriangleV3_X <= Tri_V3_X;
          Cop_TriangleV3_Y <= Tri_V3_Y;
          Cop_TriangleV3_Z <= Tri_V3_Z;
        end
        WAIT: if (Cop_Ready) begin
          code <= Cop_Code;
          hitT <= Cop_T;
        end
        COMPARE: begin
          if (hitBetter) begin
            Res_Hit   <= 1'b1;
            Res_Index <= idx[C_ADDR_WIDTH-1:0];
            Res_T     <= hitT;
          end
          idx <= idxInc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_scene_dispatcher.sv
// Scoreboard bench for ray_scene_dispatcher with triangle RAM and
// fixed-latency coprocessor models.
module tb_ray_scene_dispatcher;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int LAT = 3;
  localparam logic [DW-1:0] RSX = 32'h0001_8000;
  localparam logic [DW-1:0] RDZ = 32'hFFFF_0000;

  logic          Clk = 0;
  logic          Reset = 1;
  logic          Cmd_Start = 0;
  logic [DW-1:0] Cmd_RayStart_X = '0, Cmd_RayStart_Y = '0, Cmd_RayStart_Z = '0;
  logic [DW-1:0] Cmd_RayDir_X = '0, Cmd_RayDir_Y = '0, Cmd_RayDir_Z = '0;
  logic [AW:0]   Cmd_NumTriangles = '0;
  logic          Cmd_AnyHit = 0;
  logic          Cmd_Busy, Tri_Rd;
  logic [AW-1:0] Tri_Addr;
  logic [DW-1:0] Tri_V1_X, Tri_V1_Y, Tri_V1_Z;
  logic [DW-1:0] Tri_V2_X, Tri_V2_Y, Tri_V2_Z;
  logic [DW-1:0] Tri_V3_X, Tri_V3_Y, Tri_V3_Z;
  logic          Cop_Start;
  logic [DW-1:0] Cop_RayStart_X, Cop_RayStart_Y, Cop_RayStart_Z;
  logic [DW-1:0] Cop_RayDir_X, Cop_RayDir_Y, Cop_RayDir_Z;
  logic [DW-1:0] Cop_TriangleV1_X, Cop_TriangleV1_Y, Cop_TriangleV1_Z;
  logic [DW-1:0] Cop_TriangleV2_X, Cop_TriangleV2_Y, Cop_TriangleV2_Z;
  logic [DW-1:0] Cop_TriangleV3_X, Cop_TriangleV3_Y, Cop_TriangleV3_Z;
  logic          Cop_Ready;
  logic [1:0]    Cop_Code;
  logic [DW-1:0] Cop_T;
  logic          Res_Done, Res_Hit;
  logic [AW-1:0] Res_Index;
  logic [DW-1:0] Res_T;

  ray_scene_dispatcher #(.C_SLV_DWIDTH(DW), .C_ADDR_WIDTH(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Cmd_Start(Cmd_Start),
    .Cmd_RayStart_X(Cmd_RayStart_X), .Cmd_RayStart_Y(Cmd_RayStart_Y),
    .Cmd_RayStart_Z(Cmd_RayStart_Z), .Cmd_RayDir_X(Cmd_RayDir_X),
    .Cmd_RayDir_Y(Cmd_RayDir_Y), .Cmd_RayDir_Z(Cmd_RayDir_Z),
    .Cmd_NumTriangles(Cmd_NumTriangles),
`ifdef RAY_ANY_HIT_EN
    .Cmd_AnyHit(Cmd_AnyHit),
`endif
    .Cmd_Busy(Cmd_Busy), .Tri_Rd(Tri_Rd), .Tri_Addr(Tri_Addr),
    .Tri_V1_X(Tri_V1_X), .Tri_V1_Y(Tri_V1_Y), .Tri_V1_Z(Tri_V1_Z),
    .Tri_V2_X(Tri_V2_X), .Tri_V2_Y(Tri_V2_Y), .Tri_V2_Z(Tri_V2_Z),
    .Tri_V3_X(Tri_V3_X), .Tri_V3_Y(Tri_V3_Y), .Tri_V3_Z(Tri_V3_Z),
    .Cop_Start(Cop_Start),
    .Cop_RayStart_X(Cop_RayStart_X), .Cop_RayStart_Y(Cop_RayStart_Y),
    .Cop_RayStart_Z(Cop_RayStart_Z), .Cop_RayDir_X(Cop_RayDir_X),
    .Cop_RayDir_Y(Cop_RayDir_Y), .Cop_RayDir_Z(Cop_RayDir_Z),
    .Cop_TriangleV1_X(Cop_TriangleV1_X), .Cop_TriangleV1_Y(Cop_TriangleV1_Y),
    .Cop_TriangleV1_Z(Cop_TriangleV1_Z), .Cop_TriangleV2_X(Cop_TriangleV2_X),
    .Cop_TriangleV2_Y(Cop_TriangleV2_Y), .Cop_TriangleV2_Z(Cop_TriangleV2_Z),
    .Cop_TriangleV3_X(Cop_TriangleV3_X), .Cop_TriangleV3_Y(Cop_TriangleV3_Y),
    .Cop_TriangleV3_Z(Cop_TriangleV3_Z),
    .Cop_Ready(Cop_Ready), .Cop_Code(Cop_Code), .Cop_T(Cop_T),
    .Res_Done(Res_Done), .Res_Hit(Res_Hit), .Res_Index(Res_Index),
    .Res_T(Res_T)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          hit;
    int          idx;
    logic [31:0] t;
    int          starts;
  } exp_t;

  exp_t        sb[$];
  int          nCmp = 0;
  int          nFail = 0;
  int          startCnt = 0;
  logic [1:0]  codeTab[256];
  logic [31:0] tTab[256];
  int          copCnt = 0;
  int          copIdx = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] vtx(int a, int k);
    return 32'(a * 16 + k);
  endfunction

  // triangle RAM: vertex coordinate k of triangle a holds a*16+k
  always @(posedge Clk) if (Tri_Rd) begin
    Tri_V1_X <= vtx(Tri_Addr, 0); Tri_V1_Y <= vtx(Tri_Addr, 1);
    Tri_V1_Z <= vtx(Tri_Addr, 2); Tri_V2_X <= vtx(Tri_Addr, 3);
    Tri_V2_Y <= vtx(Tri_Addr, 4); Tri_V2_Z <= vtx(Tri_Addr, 5);
    Tri_V3_X <= vtx(Tri_Addr, 6); Tri_V3_Y <= vtx(Tri_Addr, 7);
    Tri_V3_Z <= vtx(Tri_Addr, 8);
  end

  // coprocessor: Ready in the LAT-th WAIT cycle, answer looked up by triangle
  always @(posedge Clk or posedge Reset) begin
    if (Reset) copCnt <= 0;
    else if (Cop_Start) begin
      copCnt <= LAT;
      copIdx <= int'(Cop_TriangleV1_X >> 4) & 255;
    end else if (copCnt > 0) copCnt <= copCnt - 1;
  end
  assign Cop_Ready = (copCnt == 1);
  assign Cop_Code  = Cop_Ready ? codeTab[copIdx] : 2'b01;
  assign Cop_T     = Cop_Ready ? tTab[copIdx] : 32'h0000_0100;

  // monitor
  always @(negedge Clk) begin
    if (Reset) startCnt = 0;
    else begin
      if (Cop_Start) begin
        chk("copTriV1X", Cop_TriangleV1_X, vtx(startCnt, 0));
        chk("copTriV3Z", Cop_TriangleV3_Z, vtx(startCnt, 8));
        chk("copRay", {Cop_RayStart_X, Cop_RayDir_Z}, {RSX, RDZ});
        startCnt++;
      end
      if (Res_Done) begin
        if (sb.size() == 0) chk("unexpectedDone", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("resHit", Res_Hit, e.hit);
          chk("resIndex", Res_Index, e.idx);
          chk("resT", Res_T, e.t);
          chk("copStarts", startCnt, e.starts);
        end
        startCnt = 0;
      end
    end
  end

  task automatic clearTab();
    for (int i = 0; i < 256; i++) begin
      codeTab[i] = 2'b00;
      tTab[i] = '0;
    end
  endtask

  task automatic runCmd(input int n, input bit any, input bit hit, input int idx,
                        input logic [31:0] t, input int starts, input bit mid,
                        output int cyc);
    exp_t e;
    e.hit = hit; e.idx = idx; e.t = t; e.starts = starts;
    sb.push_back(e);
    @(negedge Clk);
    Cmd_Start = 1;
    Cmd_NumTriangles = (AW + 1)'(n);
    Cmd_AnyHit = any;
    Cmd_RayStart_X = RSX;
    Cmd_RayDir_Z = RDZ;
    @(negedge Clk);
    Cmd_Start = 0;
    Cmd_RayStart_X = '0;
    Cmd_RayDir_Z = '0;
    cyc = 1;
    while (!Res_Done && cyc < 5000) begin
      if (mid && cyc == 10) begin
        Cmd_Start = 1;
        Cmd_NumTriangles = '0;
      end
      if (mid && cyc == 11) begin
        Cmd_Start = 0;
        chk("busyAfterMidStart", Cmd_Busy, 1);
      end
      @(negedge Clk);
      cyc++;
    end
    if (!Res_Done) chk("doneTimeout", 0, 1);
    @(negedge Clk);
  endtask

  initial begin
    int cyc;
    int seen;
    clearTab();
    #1;
    chk("rstOuts", {Cmd_Busy, Tri_Rd, Cop_Start, Res_Done, Res_Hit}, 0);
    chk("rstIdxT", {Res_Index, Res_T}, 0);
    repeat (3) @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
    chk("idleBusy", Cmd_Busy, 0);

    runCmd(0, 0, 0, 0, 0, 0, 0, cyc);
    chk("emptyDoneLatency", cyc, 2);

    clearTab();
    codeTab[0] = 2'b01; tTab[0] = 32'h0003_0000;
    codeTab[1] = 2'b01; tTab[1] = 32'h0001_0000;
    codeTab[2] = 2'b01; tTab[2] = 32'h0002_0000;
    runCmd(3, 0, 1, 1, 32'h0001_0000, 3, 0, cyc);
    chk("threeTriLatency", cyc, 3 * (4 + LAT) + 2);
    chk("resHold", {Res_Hit, Res_Index, Res_T}, {1'b1, 8'd1, 32'h0001_0000});

    clearTab();
    codeTab[0] = 2'b01; tTab[0] = 32'hFFFF_0000;
    codeTab[1] = 2'b00; tTab[1] = 32'h0001_0000;
    codeTab[2] = 2'b01; tTab[2] = 32'h0000_0000;
    runCmd(3, 0, 0, 0, 0, 3, 0, cyc);

    clearTab();
    codeTab[0] = 2'b11; tTab[0] = 32'h0001_0000;
    codeTab[1] = 2'b01; tTab[1] = 32'h0004_0000;
    codeTab[2] = 2'b01; tTab[2] = 32'h0002_0000;
    codeTab[3] = 2'b10; tTab[3] = 32'h0000_8000;
    codeTab[5] = 2'b01; tTab[5] = 32'h0002_0000;
    runCmd(6, 0, 1, 2, 32'h0002_0000, 6, 1, cyc);

    clearTab();
    codeTab[0] = 2'b01; tTab[0] = 32'h0006_0000;
    codeTab[255] = 2'b01; tTab[255] = 32'h0005_0000;
    runCmd(256, 0, 1, 255, 32'h0005_0000, 256, 0, cyc);

`ifdef RAY_ANY_HIT_EN
    clearTab();
    codeTab[1] = 2'b01; tTab[1] = 32'h0003_0000;
    codeTab[2] = 2'b01; tTab[2] = 32'h0001_0000;
    codeTab[3] = 2'b01; tTab[3] = 32'h0002_0000;
    runCmd(4, 1, 1, 1, 32'h0003_0000, 2, 0, cyc);
    runCmd(4, 0, 1, 2, 32'h0001_0000, 4, 0, cyc);
`endif

    // reset while waiting on the second triangle's answer
    clearTab();
    codeTab[0] = 2'b01; tTab[0] = 32'h0003_0000;
    codeTab[1] = 2'b01; tTab[1] = 32'h0001_0000;
    codeTab[2] = 2'b01; tTab[2] = 32'h0002_0000;
    @(negedge Clk);
    Cmd_Start = 1;
    Cmd_NumTriangles = 9'd3;
    Cmd_RayStart_X = RSX;
    Cmd_RayDir_Z = RDZ;
    @(negedge Clk);
    Cmd_Start = 0;
    seen = 0;
    for (int i = 0; i < 100 && seen < 2; i++) begin
      if (Cop_Start) seen++;
      if (seen < 2) @(negedge Clk);
    end
    chk("secondIssueSeen", seen, 2);
    @(negedge Clk);
    chk("preResetHit", {Res_Hit, Res_T}, {1'b1, 32'h0003_0000});
    Reset = 1;
    #1;
    chk("rstMidBusyStart", {Cmd_Busy, Cop_Start, Tri_Rd, Res_Done}, 0);
    chk("rstMidRes", {Res_Hit, Res_Index, Res_T}, 0);
    repeat (2) @(negedge Clk);
    Reset = 0;
    repeat (40) @(negedge Clk);
    chk("idleAfterReset", Cmd_Busy, 0);

    runCmd(0, 0, 0, 0, 0, 0, 0, cyc);
    chk("emptyAfterReset", cyc, 2);

    repeat (5) @(negedge Clk);
    chk("queueEmpty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
